// File: rtl/pe_input_feeder_pkg.sv
// Shared PE configuration: feeder state encoding, index widths and the
// per-run configuration captured on an accepted start.
package pe_input_feeder_pkg;

   localparam int MAXROWW = 8;
   localparam int MAXPCH  = 4;
   localparam int MAXTW   = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } feed_state_t;

   typedef struct packed {
      logic [MAXPCH-1:0]  pch;
      logic [MAXROWW-1:0] rowtile;
   } feed_cfg_t;

   // Pixels needed by one row tile; 11 bits so the range check sees overflow.
   function automatic logic [10:0] calc_rowtile(input logic [MAXTW-1:0] tw,
                                                input logic [3:0] stride,
                                                input logic [3:0] r);
      return 11'(tw) * 11'(stride) + 11'(r) - 11'd1;
   endfunction

endpackage

// File: rtl/pe_input_feeder_fifo.sv
// Two-entry output FIFO for the feeder; slot 0 is always the head so the
// presented beat holds still while the consumer stalls.
module pe_feed_fifo
   import pe_input_feeder_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic [DW-1:0]      push_dat,
   input  logic [MAXPCH-1:0]  push_ch,
   input  logic [MAXROWW-1:0] push_pix,
   input  logic               pop,
   output logic               vld,
   output logic [1:0]         occ,
   output logic [DW-1:0]      head_dat,
   output logic [MAXPCH-1:0]  head_ch,
   output logic [MAXROWW-1:0] head_pix
);

   localparam int EW = DW + MAXPCH + MAXROWW;

   logic [1:0][EW-1:0] slot_q;
   logic [1:0]         cnt_q;
   logic [EW-1:0]      din;
   logic               do_pop;

   assign din    = {push_dat, push_ch, push_pix};
   assign do_pop = pop && (cnt_q != 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
         cnt_q  <= '0;
      end else if (flush) begin
         cnt_q <= '0;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               if (cnt_q == 2'd0) slot_q[0] <= din;
               else               slot_q[1] <= din;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               slot_q[0] <= slot_q[1];
               cnt_q     <= cnt_q - 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  slot_q[0] <= din;
               end else begin
                  slot_q[0] <= slot_q[1];
                  slot_q[1] <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign vld = (cnt_q != 2'd0);
   assign occ = cnt_q;
   assign {head_dat, head_ch, head_pix} = slot_q[0];

endmodule

// File: rtl/pe_input_feeder.sv
// Streams one row tile of pixels from the line buffer to a PE, pixel-outer
// and channel-inner, through a 2-entry FIFO with read-ahead throttling.
module pe_input_feeder
   import pe_input_feeder_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 10
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic [3:0]         i_pch,
   input  logic [5:0]         i_tw,
   input  logic [3:0]         i_r,
   input  logic [3:0]         i_u,
   input  logic               i_pixreuse,
   input  logic [9:0]         i_base,
   output logic               o_rd_en,
   output logic [AW-1:0]      o_rd_addr,
   input  logic [DW-1:0]      i_rd_dat,
   output logic               Input_rdy,
   input  logic               Input_ack,
   output logic [DW-1:0]      Input_dat,
   output logic [3:0]         Input_ch,
   output logic [7:0]         Input_pix,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_cfg_err
);

   feed_state_t        state_q, state_d;
   feed_cfg_t          cfg_q;
   logic [MAXROWW-1:0] nxt_pix_q, fl_pix_q, iss_pix;
   logic [MAXPCH-1:0]  nxt_ch_q, fl_ch_q, iss_ch, pch_src;
   logic [AW-1:0]      rd_addr_q, iss_addr;
   logic               rd_en_q, rd_all_q, done_q, err_q;
   logic [3:0]         stride;
   logic [10:0]        rowtile_calc;
   logic               cfg_ok, start_ok, pop, room, iss, iss_last, head_last;
   logic               fifo_vld;
   logic [1:0]         occ;
   logic [DW-1:0]      head_dat;
   logic [MAXPCH-1:0]  head_ch;
   logic [MAXROWW-1:0] head_pix;

   assign stride       = i_pixreuse ? i_u : i_r;
   assign rowtile_calc = calc_rowtile(i_tw, stride, i_r);
   assign cfg_ok       = (i_pch != 4'd0) && (i_tw != 6'd0) && (i_r != 4'd0) &&
                         (stride != 4'd0) && (rowtile_calc <= 11'd255);
   assign start_ok     = (state_q == ST_IDLE) && i_start && !i_stop && cfg_ok;
   assign pop          = fifo_vld && Input_ack;
   // A pop this cycle frees a slot in time for a read launched now.
   assign room         = ({1'b0, occ} + {2'b00, rd_en_q}) < (3'd2 + {2'b00, pop});
   assign head_last    = (head_pix == cfg_q.rowtile) && (head_ch == cfg_q.pch);

   always_comb begin
      iss      = 1'b0;
      iss_last = 1'b0;
      iss_pix  = nxt_pix_q;
      iss_ch   = nxt_ch_q;
      iss_addr = rd_addr_q + AW'(1);
      pch_src  = cfg_q.pch;
      if (start_ok) begin
         iss      = 1'b1;
         iss_pix  = MAXROWW'(1);
         iss_ch   = MAXPCH'(1);
         iss_addr = AW'(i_base);
         pch_src  = i_pch;
         iss_last = (rowtile_calc == 11'd1) && (i_pch == 4'd1);
      end else if (state_q == ST_RUN && !rd_all_q && !i_stop && room) begin
         iss      = 1'b1;
         iss_last = (nxt_pix_q == cfg_q.rowtile) && (nxt_ch_q == cfg_q.pch);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_ok) state_d = ST_RUN;
         ST_RUN: begin
            if (i_stop)                            state_d = ST_IDLE;
            else if (rd_all_q || (iss && iss_last)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (i_stop)                  state_d = ST_IDLE;
            else if (pop && head_last)   state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         cfg_q     <= '0;
         nxt_pix_q <= '0;
         nxt_ch_q  <= '0;
         fl_pix_q  <= '0;
         fl_ch_q   <= '0;
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
         rd_all_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_en_q <= iss;
         done_q  <= (state_q == ST_DRAIN) && pop && head_last && !i_stop;
         err_q   <= (state_q == ST_IDLE) && i_start && !i_stop && !cfg_ok;
         if (start_ok) cfg_q <= '{pch: i_pch, rowtile: rowtile_calc[7:0]};
         if (state_d == ST_IDLE) rd_all_q <= 1'b0;
         else if (iss)           rd_all_q <= iss_last;
         if (iss) begin
            rd_addr_q <= iss_addr;
            fl_pix_q  <= iss_pix;
            fl_ch_q   <= iss_ch;
            if (iss_ch == pch_src) begin
               nxt_ch_q  <= MAXPCH'(1);
               nxt_pix_q <= iss_pix + MAXROWW'(1);
            end else begin
               nxt_ch_q  <= iss_ch + MAXPCH'(1);
               nxt_pix_q <= iss_pix;
            end
         end
      end
   end

   // Returning read data is tagged with the indices captured at issue.
   pe_feed_fifo #(.DW(DW)) u_fifo (
      .clk      (i_clk),
      .rst      (i_rst),
      .flush    (i_stop && (state_q != ST_IDLE)),
      .push     (rd_en_q),
      .push_dat (i_rd_dat),
      .push_ch  (fl_ch_q),
      .push_pix (fl_pix_q),
      .pop      (pop),
      .vld      (fifo_vld),
      .occ      (occ),
      .head_dat (head_dat),
      .head_ch  (head_ch),
      .head_pix (head_pix)
   );

   assign o_rd_en   = rd_en_q;
   assign o_rd_addr = rd_addr_q;
   assign Input_rdy = fifo_vld;
   assign Input_dat = head_dat;
   assign Input_ch  = head_ch;
   assign Input_pix = head_pix;
   assign o_busy    = (state_q != ST_IDLE);
   assign o_done    = done_q;
   assign o_cfg_err = err_q;

endmodule

// File: tb/tb_pe_input_feeder.sv
// Directed bench for pe_input_feeder; buffer returns 0xA000 | address.
module tb_pe_input_feeder;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start, i_stop;
   logic [3:0]  i_pch, i_r, i_u;
   logic [5:0]  i_tw;
   logic        i_pixreuse;
   logic [9:0]  i_base;
   logic        o_rd_en;
   logic [9:0]  o_rd_addr;
   logic [15:0] i_rd_dat;
   logic        Input_rdy, Input_ack;
   logic [15:0] Input_dat;
   logic [3:0]  Input_ch;
   logic [7:0]  Input_pix;
   logic        o_busy, o_done, o_cfg_err;

   int checks = 0;
   int errors = 0;
   int nrd;

   always #5 i_clk = ~i_clk;

   assign i_rd_dat = 16'hA000 | {6'h00, o_rd_addr};

   pe_input_feeder #(.DW(16), .AW(10)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_stop(i_stop),
      .i_pch(i_pch), .i_tw(i_tw), .i_r(i_r), .i_u(i_u),
      .i_pixreuse(i_pixreuse), .i_base(i_base),
      .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_dat(i_rd_dat),
      .Input_rdy(Input_rdy), .Input_ack(Input_ack), .Input_dat(Input_dat),
      .Input_ch(Input_ch), .Input_pix(Input_pix),
      .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic set_cfg(input int pch, input int tw, input int r, input int u,
                          input int pr, input int base);
      i_pch      = 4'(pch);
      i_tw       = 6'(tw);
      i_r        = 4'(r);
      i_u        = 4'(u);
      i_pixreuse = 1'(pr);
      i_base     = 10'(base);
   endtask

   task automatic start_pulse();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   // Called with beat 1 on the bus and ack high; checks every beat then o_done.
   task automatic stream(input int pch, input int nbeat, input int base);
      logic [9:0] a;
      for (int k = 0; k < nbeat; k++) begin
         a = 10'(base + k);
         chk("rdy",  32'(Input_rdy), 1);
         chk("dat",  32'(Input_dat), 32'(16'hA000 | {6'h00, a}));
         chk("pix",  32'(Input_pix), k / pch + 1);
         chk("ch",   32'(Input_ch),  k % pch + 1);
         tick();
      end
      chk("done_pulse", 32'(o_done),    1);
      chk("busy_end",   32'(o_busy),    0);
      chk("rdy_end",    32'(Input_rdy), 0);
      tick();
      chk("done_clear", 32'(o_done),    0);
   endtask

   initial begin
      i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; Input_ack = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_rd_en",  32'(o_rd_en),   0);
      chk("rst_addr",   32'(o_rd_addr), 0);
      chk("rst_rdy",    32'(Input_rdy), 0);
      chk("rst_dat",    32'(Input_dat), 0);
      chk("rst_ch",     32'(Input_ch),  0);
      chk("rst_pix",    32'(Input_pix), 0);
      chk("rst_busy",   32'(o_busy),    0);
      chk("rst_done",   32'(o_done),    0);
      chk("rst_err",    32'(o_cfg_err), 0);
      tick();
      i_rst = 1'b0;
      tick();

      // pch=2 rowtile=4, full-rate stream, first-beat latency
      set_cfg(2, 2, 3, 1, 1, 'h10);
      Input_ack = 1'b1;
      start_pulse();
      chk("t1_busy",  32'(o_busy),    1);
      chk("t1_rd_en", 32'(o_rd_en),   1);
      chk("t1_addr",  32'(o_rd_addr), 'h10);
      chk("t1_rdy0",  32'(Input_rdy), 0);
      tick();
      stream(2, 8, 'h10);

      // pixreuse=0: rowtile=8, single channel
      set_cfg(1, 2, 3, 1, 0, 'h40);
      start_pulse();
      tick();
      stream(1, 8, 'h40);

      // single-beat run
      set_cfg(1, 1, 1, 1, 0, 'h55);
      start_pulse();
      tick();
      stream(1, 1, 'h55);

      // consumer stall: head holds, no more than 2 reads ahead
      Input_ack = 1'b0;
      set_cfg(2, 2, 3, 1, 1, 'h20);
      start_pulse();
      nrd = int'(o_rd_en);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_rdy", 32'(Input_rdy), 1);
         chk("stall_dat", 32'(Input_dat), 'hA020);
         chk("stall_pix", 32'(Input_pix), 1);
         chk("stall_ch",  32'(Input_ch),  1);
         nrd += int'(o_rd_en);
      end
      chk("stall_reads", 32'(nrd), 2);
      Input_ack = 1'b1;
      stream(2, 8, 'h20);

      // rowtile overflow and zero channels are rejected
      set_cfg(1, 63, 15, 1, 0, 0);
      start_pulse();
      chk("ovf_err",   32'(o_cfg_err), 1);
      chk("ovf_busy",  32'(o_busy),    0);
      chk("ovf_rd_en", 32'(o_rd_en),   0);
      tick();
      chk("ovf_err_clr", 32'(o_cfg_err), 0);
      chk("ovf_busy2",   32'(o_busy),    0);
      set_cfg(0, 2, 3, 1, 1, 0);
      start_pulse();
      chk("pch0_err",  32'(o_cfg_err), 1);
      chk("pch0_busy", 32'(o_busy),    0);
      tick();

      // stop beats a simultaneous start
      set_cfg(2, 2, 3, 1, 1, 'h10);
      i_stop = 1'b1;
      start_pulse();
      i_stop = 1'b0;
      chk("stopstart_busy", 32'(o_busy),    0);
      chk("stopstart_err",  32'(o_cfg_err), 0);
      tick();

      // abort after beat 3, then a clean restart
      start_pulse();
      tick();
      for (int k = 0; k < 3; k++) begin
         chk("ab_pix", 32'(Input_pix), k / 2 + 1);
         chk("ab_ch",  32'(Input_ch),  k % 2 + 1);
         tick();
      end
      chk("ab_beat4_pix", 32'(Input_pix), 2);
      chk("ab_beat4_ch",  32'(Input_ch),  2);
      i_stop = 1'b1;
      tick();
      i_stop = 1'b0;
      chk("ab_busy",  32'(o_busy),    0);
      chk("ab_rdy",   32'(Input_rdy), 0);
      chk("ab_rd_en", 32'(o_rd_en),   0);
      chk("ab_done",  32'(o_done),    0);
      tick();
      chk("ab_done2", 32'(o_done),    0);
      chk("ab_rdy2",  32'(Input_rdy), 0);
      start_pulse();
      tick();
      stream(2, 8, 'h10);

      // address wrap at the top of the buffer
      set_cfg(4, 1, 1, 1, 0, 'h3FE);
      start_pulse();
      chk("wrap_addr0", 32'(o_rd_addr), 'h3FE);
      tick();
      stream(4, 4, 'h3FE);

      // reset mid-transfer drops everything
      set_cfg(2, 2, 3, 1, 1, 'h10);
      start_pulse();
      tick();
      tick();
      i_rst = 1'b1;
      #1;
      chk("mrst_busy",  32'(o_busy),    0);
      chk("mrst_rdy",   32'(Input_rdy), 0);
      chk("mrst_rd_en", 32'(o_rd_en),   0);
      chk("mrst_dat",   32'(Input_dat), 0);
      chk("mrst_addr",  32'(o_rd_addr), 0);
      i_rst = 1'b0;
      tick();
      chk("mrst_done",  32'(o_done),    0);
      chk("mrst_busy2", 32'(o_busy),    0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_input_feeder.md
PE_INPUT_FEEDER -- requirements
Module: pe_input_feeder

Interface
REQ-001 SHALL have parameter DW, default 16, meaning input pixel data width.
REQ-002 SHALL have parameter AW, default 10, meaning buffer read address width.
REQ-003 SHALL have ports i_clk input 1 (clock) and i_rst input 1 (asynchronous active-high reset); one clock, no other clock or reset.
REQ-004 SHALL have i_start input 1: start pulse, sampled in IDLE only.
REQ-005 SHALL have i_stop input 1: synchronous abort.
REQ-006 SHALL have cfg inputs i_pch 4, i_tw 6, i_r 4, i_u 4, i_pixreuse 1, i_base 10; captured on accepted start.
REQ-007 SHALL have buffer read port o_rd_en output 1, o_rd_addr output AW, i_rd_dat input DW; data is valid exactly 1 cycle after o_rd_en.
REQ-008 SHALL have Input stream (sender side) Input_rdy output 1, Input_ack input 1, Input_dat output DW, Input_ch output 4, Input_pix output 8.
REQ-009 SHALL have o_busy output 1, o_done output 1 (1-cycle pulse), o_cfg_err output 1 (1-cycle pulse).

Function
REQ-010 SHALL compute stride = i_pixreuse ? i_u : i_r, and rowtile = i_tw*stride + i_r - 1 in 11-bit arithmetic.
REQ-011 SHALL reject start (pulse o_cfg_err, stay IDLE) if i_pch==0, i_tw==0, i_r==0, stride==0, or rowtile>255.
REQ-012 SHALL use states IDLE, RUN, DRAIN: IDLE->RUN on valid start; RUN->DRAIN when last read issued; DRAIN->IDLE when last beat acked.
REQ-013 SHALL order transfers pixel-outer, channel-inner: for pix 1..rowtile, ch 1..pch; 1-based indices on Input_pix/Input_ch.
REQ-014 SHALL issue reads at addresses i_base, i_base+1, ... for pch*rowtile beats; address wraps modulo 2^AW.
REQ-015 SHALL hold a 2-entry output FIFO; issue a read only when occupancy + in-flight reads < 2.
REQ-016 SHALL assert Input_rdy iff FIFO non-empty; transfer occurs on Input_rdy && Input_ack.
REQ-017 SHALL hold Input_dat/ch/pix stable while Input_rdy && !Input_ack.
REQ-018 SHALL sustain one beat per cycle when Input_ack is held high (read issued same cycle as pop).
REQ-019 SHALL accept a read return and a pop in the same cycle with occupancy unchanged.
REQ-020 SHALL pulse o_done the cycle after the final transfer; o_busy high in RUN and DRAIN.
REQ-021 SHALL on i_stop in RUN/DRAIN flush FIFO, discard in-flight return, go IDLE next cycle, no o_done.
REQ-022 SHALL ignore i_start while busy; i_stop in IDLE has no effect; i_stop wins over simultaneous i_start.
REQ-023 SHALL first-beat latency: o_rd_en the cycle after start, Input_rdy two cycles after start.

Reset
REQ-024 SHALL on i_rst force IDLE, empty FIFO, clear in-flight flag and counters.
REQ-025 SHALL reset outputs: o_rd_en 0, o_rd_addr 0, Input_rdy 0, Input_dat 0, Input_ch 0, Input_pix 0, o_busy 0, o_done 0, o_cfg_err 0.
REQ-026 SHALL on reset mid-transfer drop all pending beats; no o_done.

Structure
REQ-027 SHALL place state enum, MAXROWW=8, MAXPCH=4, MAXTW=6 constants and feeder cfg struct in the shared PE config package.
REQ-028 SHALL instantiate one sub-module, pe_feed_fifo (2-entry FIFO carrying dat/ch/pix); index counters inline.

Verification
REQ-029 SHALL test pch=2, r=3, u=1, pixreuse=1, tw=2, base=0x10, ack always 1 -> rowtile=4, 8 beats addr 0x10..0x17, (pix,ch)=(1,1),(1,2)..(4,2), one beat/cycle, o_done cycle after beat 8.
REQ-030 SHALL test pixreuse=0, r=3, tw=2, pch=1 -> rowtile=8, 8 beats pix 1..8.
REQ-031 SHALL test ack low 5 cycles then high -> rdy held, data stable, at most 2 reads outstanding, no beat lost or duplicated.
REQ-032 SHALL test tw=63, r=15, pixreuse=0 -> rowtile>255, o_cfg_err pulse, o_busy stays 0.
REQ-033 SHALL test i_stop after beat 3 -> IDLE next cycle, Input_rdy 0, no o_done; new start succeeds from beat 1.
REQ-034 SHALL test base=0x3FE, 4 beats -> addresses 0x3FE,0x3FF,0x000,0x001.
